button_conditioner: RTL and testbench

Conditions the raw board push-buttons (up/down/left/right/centre) before they reach the arithmetic/display top level. Each input passes through a two-flop synchroniser and a saturating debounce counter. The block then produces a clean level plus single-cycle press, release and auto-repeat strobes in the `clk` domain. With these strobes, downstream logic (store register, value select) can run synchronously on `clk` instead of clocking directly off a button edge.

---
 rtl/button_conditioner.sv | 157 +++++++++++++++
 tb/tb_button_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions raw push-button pins into clean, clk-synchronous signals. Each
// channel has a two-flop synchroniser, a debounce counter that must see
// DEBOUNCE_CYCLES consecutive mismatching samples before the debounced level
// changes, single-cycle press/release strobes, and an optional auto-repeat
// strobe while the button is held.
//
// Ports:
//   clk          system clock, all state updates on its rising edge
//   rst          asynchronous, active-high reset
//   btn_raw      unsynchronised button pins, bit i = channel i
//   btn_level    debounced state (1 = pressed)
//   btn_press    one-cycle strobe in the first cycle btn_level is 1
//   btn_release  one-cycle strobe in the first cycle btn_level is 0
//   btn_repeat   one-cycle auto-repeat strobe while held
//
// Per-channel debounce FSM:
//   state     | meaning
//   IDLE      | level 0, no pending change
//   ARMING    | level 0, dc > 0 consecutive high samples seen
//   HELD      | level 1, no pending change
//   DISARMING | level 1, dc > 0 consecutive low samples seen
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DC_W-1:0] DC_TERM = DC_W'(DEBOUNCE_CYCLES);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W = $clog2(RPT_MAX + 1);
    localparam logic [RC_W-1:0] RC_DELAY  = RC_W'(REPEAT_DELAY);
    localparam logic [RC_W-1:0] RC_PERIOD = RC_W'(REPEAT_PERIOD);
    localparam bit RPT_EN = (REPEAT_DELAY != 0);

    // Bit 1 of the encoding is the debounced level, so btn_level comes
    // straight off a flop with no decode glitches.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        HELD      = 2'b10,
        DISARMING = 2'b11
    } chanState_t;

    for (genvar i = 0; i < N_BTN; i++) begin : gChan
        logic            s1, s2;
        chanState_t      state, stateNext;
        logic [DC_W-1:0] dc, dcNext, dcInc;
        logic            pressNext, releaseNext;
        logic            pressQ, releaseQ, repeatQ;
        logic [RC_W-1:0] rc, rcInc, rcTarget;
        logic            rptPhase;
        logic            holding;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= btn_raw[i];
                s2 <= s1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= IDLE;
                dc       <= '0;
                pressQ   <= 1'b0;
                releaseQ <= 1'b0;
            end else begin
                state    <= stateNext;
                dc       <= dcNext;
                pressQ   <= pressNext;
                releaseQ <= releaseNext;
            end
        end

        assign dcInc = dc + DC_W'(1);

        always_comb begin
            stateNext   = state;
            dcNext      = '0;
            pressNext   = 1'b0;
            releaseNext = 1'b0;
            case (state)
                IDLE, ARMING: begin
                    if (!s2) begin
                        stateNext = IDLE;
                    end else if (dcInc == DC_TERM) begin
                        stateNext = HELD;
                        pressNext = 1'b1;
                    end else begin
                        stateNext = ARMING;
                        dcNext    = dcInc;
                    end
                end
                HELD, DISARMING: begin
                    if (s2) begin
                        stateNext = HELD;
                    end else if (dcInc == DC_TERM) begin
                        stateNext   = IDLE;
                        releaseNext = 1'b1;
                    end else begin
                        stateNext = DISARMING;
                        dcNext    = dcInc;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end

        // Level is 1 both before and after this edge: excludes the press edge
        // (rc restarts) and the release edge (repeat stops at once).
        assign holding  = state[1] & stateNext[1];
        assign rcInc    = rc + RC_W'(1);
        // First interval runs to REPEAT_DELAY, later ones to REPEAT_PERIOD;
        // rc returns to 0 on every strobe so it never runs past its width.
        assign rcTarget = rptPhase ? RC_PERIOD : RC_DELAY;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rc       <= '0;
                rptPhase <= 1'b0;
                repeatQ  <= 1'b0;
            end else if (!RPT_EN || !holding) begin
                rc       <= '0;
                rptPhase <= 1'b0;
                repeatQ  <= 1'b0;
            end else if (rcInc == rcTarget) begin
                rc       <= '0;
                rptPhase <= 1'b1;
                repeatQ  <= 1'b1;
            end else begin
                rc       <= rcInc;
                repeatQ  <= 1'b0;
            end
        end

        assign btn_level[i]   = state[1];
        assign btn_press[i]   = pressQ;
        assign btn_release[i] = releaseQ;
        assign btn_repeat[i]  = repeatQ;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with small timing parameters.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic         r;
        logic [N-1:0] raw, lvl, prs, rel, rpt;
    } vec_t;
    vec_t vecs[$];

    // Behavioural reference: sampled history, run length of disagreeing
    // samples, and age since press with an arithmetic repeat rule.
    logic [N-1:0] m1, m2, mLvl, mPrs, mRel, mRpt;
    int mRun[N];
    int mAge[N];

    task automatic modelEdge(input logic r, input logic [N-1:0] raw);
        if (r) begin
            m1 = '0; m2 = '0; mLvl = '0; mPrs = '0; mRel = '0; mRpt = '0;
            for (int i = 0; i < N; i++) begin
                mRun[i] = 0;
                mAge[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                logic seen;
                seen    = m2[i];
                m2[i]   = m1[i];
                m1[i]   = raw[i];
                mPrs[i] = 1'b0;
                mRel[i] = 1'b0;
                if (seen != mLvl[i]) begin
                    mRun[i]++;
                    if (mRun[i] == DB) begin
                        mLvl[i] = seen;
                        mRun[i] = 0;
                        mPrs[i] = seen;
                        mRel[i] = ~seen;
                    end
                end else begin
                    mRun[i] = 0;
                end
                if (mPrs[i]) mAge[i] = 0;
                else if (mLvl[i]) mAge[i]++;
                mRpt[i] = mLvl[i] && !mPrs[i] && (RD > 0) && (mAge[i] >= RD)
                          && (((mAge[i] - RD) % RP) == 0);
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] raw);
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        modelEdge(r, raw);
        #1;
    endtask

    function automatic logic [19:0] outs();
        return {btn_level, btn_press, btn_release, btn_repeat};
    endfunction

    task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got lvl/prs/rel/rpt=%h expected %h", nm, act, exp);
    endtask

    task automatic expCh(input string nm, input int ch,
                         input logic l, input logic p, input logic rl, input logic q);
        check(nm, {16'h0, btn_level[ch], btn_press[ch], btn_release[ch], btn_repeat[ch]},
              {16'h0, l, p, rl, q});
    endtask

    task automatic addRow(input logic r, input logic [N-1:0] raw, input logic [N-1:0] l,
                          input logic [N-1:0] p, input logic [N-1:0] rl,
                          input logic [N-1:0] q, input int n);
        vec_t v;
        v.r = r; v.raw = raw; v.lvl = l; v.prs = p; v.rel = rl; v.rpt = q;
        for (int j = 0; j < n; j++) vecs.push_back(v);
    endtask

    int bounce[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    int holdLeft[N];
    logic [N-1:0] rr;

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        modelEdge(1'b1, '0);

        // Reset with all buttons down, fresh press after release, reset
        // mid-hold, then glitch of 3 edges and a 4-edge pulse on channel 0.
        addRow(1, 5'h1F, 0, 0, 0, 0, 2);
        addRow(0, 5'h1F, 0, 0, 0, 0, 5);
        addRow(0, 5'h1F, 5'h1F, 5'h1F, 0, 0, 1);
        addRow(0, 5'h1F, 5'h1F, 0, 0, 0, 2);
        addRow(1, 5'h00, 0, 0, 0, 0, 1);
        addRow(0, 5'h01, 0, 0, 0, 0, 3);
        addRow(0, 5'h00, 0, 0, 0, 0, 6);
        addRow(0, 5'h01, 0, 0, 0, 0, 4);
        addRow(0, 5'h00, 0, 0, 0, 0, 1);
        addRow(0, 5'h00, 5'h01, 5'h01, 0, 0, 1);
        addRow(0, 5'h00, 5'h01, 0, 0, 0, 3);
        addRow(0, 5'h00, 0, 0, 5'h01, 0, 1);
        addRow(0, 5'h00, 0, 0, 0, 0, 2);
        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].r, vecs[k].raw);
            check($sformatf("vec%0d", k), outs(),
                  {vecs[k].lvl, vecs[k].prs, vecs[k].rel, vecs[k].rpt});
        end

        // Bounce on channel 2: final stable run starts at edge 5.
        step(1'b1, '0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, (k < 9 && bounce[k] == 0) ? 5'h00 : 5'h04);
            expCh($sformatf("bounce e%0d", k), 2, k >= 10, k == 10, 1'b0, 1'b0);
        end

        // Auto-repeat on channel 1: press at edge 5, raw dropped at edge 35.
        step(1'b1, '0);
        for (int e = 0; e < 46; e++) begin
            step(1'b0, (e <= 34) ? 5'h02 : 5'h00);
            expCh($sformatf("repeat e%0d", e), 1, e >= 5 && e <= 39, e == 5, e == 40,
                  e >= 15 && e <= 39 && ((e - 15) % 3 == 0));
        end

        // Independence: channel 4 held from edge 0, channel 3 from edge 12.
        step(1'b1, '0);
        for (int e = 0; e < 33; e++) begin
            step(1'b0, {1'b1, e >= 12, 3'b000});
            expCh($sformatf("indep ch4 e%0d", e), 4, e >= 5, e == 5, 1'b0,
                  e >= 15 && ((e - 15) % 3 == 0));
            expCh($sformatf("indep ch3 e%0d", e), 3, e >= 17, e == 17, 1'b0,
                  e >= 27 && ((e - 27) % 3 == 0));
        end

        // Mid-hold asynchronous reset on channel 0, then a fresh press.
        step(1'b1, '0);
        for (int e = 0; e < 14; e++) step(1'b0, 5'h01);
        expCh("midrst held", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst async", outs(), 20'h0);
        step(1'b1, 5'h01);
        check("midrst edge", outs(), 20'h0);
        for (int e = 0; e < 17; e++) begin
            step(1'b0, 5'h01);
            expCh($sformatf("midrst e%0d", e), 0, e >= 5, e == 5, 1'b0, e == 15);
        end

        // Randomised run against the reference model.
        step(1'b1, '0);
        rr = '0;
        for (int i = 0; i < N; i++) holdLeft[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (holdLeft[i] == 0) begin
                    rr[i]       = 1'($urandom_range(0, 1));
                    holdLeft[i] = $urandom_range(1, 24);
                end
                holdLeft[i]--;
            end
            step(1'b0, rr);
            check($sformatf("rand c%0d", c), outs(), {mLvl, mPrs, mRel, mRpt});
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
